hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage MIPS-style core (stall + forward selects).
// Latency: stall and Fwd_* are combinational from the inputs and the tracked M/W tags; tags advance one stage per clk.
// Backpressure: stall freezes PC and IF/ID and clears the E register; forwarding stays resolved while stalled.
//
// Ports:
//   clk, reset (sync, active-high), EXC_flush (kills M/W tags on the edge)
//   Res_E/A1_E/A2_E/A3_E : E-stage result type and register addresses
//   A1_ID/A2_ID, Tuse_rs_ID/Tuse_rt_ID : ID operands and their first-use stage
//   md_start_E, md_use_ID : multiply/divide start in E, HI/LO use in ID
//   stall, md_busy, Fwd_rs_ID/Fwd_rt_ID/Fwd_rs_E/Fwd_rt_E (00 none, 01 M, 10 W, 11 E)
//
// Build option: define HAZARD_MD_STALL_EN to enable the multiply/divide busy counter
// and its stall. Without it md_busy is 0 and stall covers register hazards only.

module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       EXC_flush,
  input  logic [1:0] Res_E,
  input  logic [4:0] A1_E,
  input  logic [4:0] A2_E,
  input  logic [4:0] A3_E,
  input  logic [4:0] A1_ID,
  input  logic [4:0] A2_ID,
  input  logic [1:0] Tuse_rs_ID,
  input  logic [1:0] Tuse_rt_ID,
  input  logic [1:0] md_start_E,
  input  logic       md_use_ID,
  output logic       stall,
  output logic [1:0] Fwd_rs_ID,
  output logic [1:0] Fwd_rt_ID,
  output logic [1:0] Fwd_rs_E,
  output logic [1:0] Fwd_rt_E,
  output logic       md_busy
);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_ALU  = 2'b01;
  localparam logic [1:0] RES_DM   = 2'b10;
  localparam logic [1:0] RES_PC   = 2'b11;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;
  localparam logic [1:0] FWD_E    = 2'b11;

  // ---------------------------------------------------------------------------
  // Tag pipeline: E -> M -> W
  // ---------------------------------------------------------------------------
  logic [1:0] res_m_q, res_m_d, res_w_q, res_w_d;
  logic [4:0] a3_m_q, a3_m_d, a3_w_q, a3_w_d;
  logic [4:0] a1_m_q, a1_m_d, a2_m_q, a2_m_d;

  always_comb begin
    res_m_d = Res_E;
    a3_m_d  = A3_E;
    a1_m_d  = A1_E;
    a2_m_d  = A2_E;
    res_w_d = res_m_q;
    a3_w_d  = a3_m_q;
    if (EXC_flush) begin
      res_m_d = RES_NONE;
      a3_m_d  = 5'd0;
      a1_m_d  = 5'd0;
      a2_m_d  = 5'd0;
      res_w_d = RES_NONE;
      a3_w_d  = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_m_q <= RES_NONE;
      a3_m_q  <= 5'd0;
      a1_m_q  <= 5'd0;
      a2_m_q  <= 5'd0;
      res_w_q <= RES_NONE;
      a3_w_q  <= 5'd0;
    end else begin
      res_m_q <= res_m_d;
      a3_m_q  <= a3_m_d;
      a1_m_q  <= a1_m_d;
      a2_m_q  <= a2_m_d;
      res_w_q <= res_w_d;
      a3_w_q  <= a3_w_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-dependency stall
  // ---------------------------------------------------------------------------
  // Tnew: cycles until the producer's result exists, counted from its current stage.
  logic [1:0] tnew_e, tnew_m;

  always_comb begin
    case (Res_E)
      RES_ALU: tnew_e = 2'd1;
      RES_DM:  tnew_e = 2'd2;
      default: tnew_e = 2'd0;
    endcase
    tnew_m = (res_m_q == RES_DM) ? 2'd1 : 2'd0;
  end

  function automatic logic dep_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] a3, input logic [1:0] res,
                                     input logic [1:0] tnew);
    return (src != 5'd0) && (src == a3) && (res != RES_NONE) && (tuse < tnew);
  endfunction

  logic reg_stall;

  always_comb begin
    reg_stall = dep_stall(A1_ID, Tuse_rs_ID, A3_E,   Res_E,   tnew_e) ||
                dep_stall(A1_ID, Tuse_rs_ID, a3_m_q, res_m_q, tnew_m) ||
                dep_stall(A2_ID, Tuse_rt_ID, A3_E,   Res_E,   tnew_e) ||
                dep_stall(A2_ID, Tuse_rt_ID, a3_m_q, res_m_q, tnew_m);
  end

  // ---------------------------------------------------------------------------
  // Forward selects: a stage is a candidate only when its result is already
  // available there; the newest ready match wins.
  // ---------------------------------------------------------------------------
  logic rdy_e, rdy_m, rdy_w;

  always_comb begin
    rdy_e = (Res_E == RES_PC);
    rdy_m = (res_m_q == RES_ALU) || (res_m_q == RES_PC);
    rdy_w = (res_w_q != RES_NONE);
  end

  function automatic logic [1:0] fwd_id(input logic [4:0] src, input logic [4:0] a3_e,
                                        input logic e_ok, input logic [4:0] a3_m,
                                        input logic m_ok, input logic [4:0] a3_w,
                                        input logic w_ok);
    if (src == 5'd0)                return FWD_NONE;
    else if (e_ok && src == a3_e)   return FWD_E;
    else if (m_ok && src == a3_m)   return FWD_M;
    else if (w_ok && src == a3_w)   return FWD_W;
    else                            return FWD_NONE;
  endfunction

  function automatic logic [1:0] fwd_ex(input logic [4:0] src, input logic [4:0] a3_m,
                                        input logic m_ok, input logic [4:0] a3_w,
                                        input logic w_ok);
    if (src == 5'd0)                return FWD_NONE;
    else if (m_ok && src == a3_m)   return FWD_M;
    else if (w_ok && src == a3_w)   return FWD_W;
    else                            return FWD_NONE;
  endfunction

  always_comb begin
    Fwd_rs_ID = fwd_id(A1_ID, A3_E, rdy_e, a3_m_q, rdy_m, a3_w_q, rdy_w);
    Fwd_rt_ID = fwd_id(A2_ID, A3_E, rdy_e, a3_m_q, rdy_m, a3_w_q, rdy_w);
    Fwd_rs_E  = fwd_ex(A1_E, a3_m_q, rdy_m, a3_w_q, rdy_w);
    Fwd_rt_E  = fwd_ex(A2_E, a3_m_q, rdy_m, a3_w_q, rdy_w);
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide occupancy
  // ---------------------------------------------------------------------------
  logic md_stall;
  logic unused_sigs;

`ifdef HAZARD_MD_STALL_EN
  logic [3:0] md_cnt_q, md_cnt_d;

  // A running operation always finishes; new starts are accepted only when idle
  // and not being flushed.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (!EXC_flush) begin
      case (md_start_E)
        2'b01:   md_cnt_d = 4'd5;
        2'b10:   md_cnt_d = 4'd10;
        default: md_cnt_d = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) md_cnt_q <= 4'd0;
    else       md_cnt_q <= md_cnt_d;
  end

  always_comb begin
    md_busy  = (md_cnt_q != 4'd0);
    md_stall = md_use_ID && (md_busy || md_start_E == 2'b01 || md_start_E == 2'b10);
  end

  assign unused_sigs = ^{a1_m_q, a2_m_q};
`else
  always_comb begin
    md_busy  = 1'b0;
    md_stall = 1'b0;
  end

  assign unused_sigs = ^{a1_m_q, a2_m_q, md_start_E, md_use_ID};
`endif

  assign stall = reg_stall || md_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with an expected-value scoreboard.
// Latency: one vector per clk; outputs are combinational and sampled on the falling edge.
// Backpressure: none; the bench plays the pipeline, clearing E itself after a stall.

module tb_hazard_ctrl;

`ifdef HAZARD_MD_STALL_EN
  localparam logic MDE = 1'b1;
`else
  localparam logic MDE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, EXC_flush;
  logic [1:0] Res_E;
  logic [4:0] A1_E, A2_E, A3_E, A1_ID, A2_ID;
  logic [1:0] Tuse_rs_ID, Tuse_rt_ID, md_start_E;
  logic       md_use_ID;
  logic       stall, md_busy;
  logic [1:0] Fwd_rs_ID, Fwd_rt_ID, Fwd_rs_E, Fwd_rt_E;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .EXC_flush  (EXC_flush),
    .Res_E      (Res_E),
    .A1_E       (A1_E),
    .A2_E       (A2_E),
    .A3_E       (A3_E),
    .A1_ID      (A1_ID),
    .A2_ID      (A2_ID),
    .Tuse_rs_ID (Tuse_rs_ID),
    .Tuse_rt_ID (Tuse_rt_ID),
    .md_start_E (md_start_E),
    .md_use_ID  (md_use_ID),
    .stall      (stall),
    .Fwd_rs_ID  (Fwd_rs_ID),
    .Fwd_rt_ID  (Fwd_rt_ID),
    .Fwd_rs_E   (Fwd_rs_E),
    .Fwd_rt_E   (Fwd_rt_E),
    .md_busy    (md_busy)
  );

  // Expected output word: {stall, md_busy, Fwd_rs_ID, Fwd_rt_ID, Fwd_rs_E, Fwd_rt_E}
  typedef struct packed {
    logic [15:0] id;
    logic [9:0]  v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [9:0] got;
      e   = exp_q.pop_front();
      got = {stall, md_busy, Fwd_rs_ID, Fwd_rt_ID, Fwd_rs_E, Fwd_rt_E};
      checks++;
      if (got !== e.v) begin
        failures++;
        $display("FAIL vec%0d {stall,busy,rsID,rtID,rsE,rtE}: got %b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b",
                 e.id, got[9], got[8], got[7:6], got[5:4], got[3:2], got[1:0],
                 e.v[9], e.v[8], e.v[7:6], e.v[5:4], e.v[3:2], e.v[1:0]);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic vec(input int id, input logic rst, input logic fl, input logic [1:0] res_e,
                     input logic [4:0] a1e, input logic [4:0] a2e, input logic [4:0] a3e,
                     input logic [4:0] a1id, input logic [4:0] a2id,
                     input logic [1:0] trs, input logic [1:0] trt,
                     input logic [1:0] mds, input logic mdu,
                     input logic st, input logic bz, input logic [1:0] f_rs_id,
                     input logic [1:0] f_rt_id, input logic [1:0] f_rs_e,
                     input logic [1:0] f_rt_e);
    exp_t e;
    reset = rst;  EXC_flush = fl;  Res_E = res_e;
    A1_E = a1e;   A2_E = a2e;      A3_E = a3e;
    A1_ID = a1id; A2_ID = a2id;    Tuse_rs_ID = trs; Tuse_rt_ID = trt;
    md_start_E = mds; md_use_ID = mdu;
    e.id = id[15:0];
    e.v  = {st, bz, f_rs_id, f_rt_id, f_rs_e, f_rt_e};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int drain;
    reset = 1'b1; EXC_flush = 1'b0; Res_E = 2'b00;
    A1_E = 5'd0; A2_E = 5'd0; A3_E = 5'd0; A1_ID = 5'd0; A2_ID = 5'd0;
    Tuse_rs_ID = 2'd0; Tuse_rt_ID = 2'd0; md_start_E = 2'b00; md_use_ID = 1'b0;
    @(posedge clk);
    #1;
    //   id rst fl res    a1e a2e a3e a1id a2id trs trt mds   mdu | st  bz  rsID   rtID   rsE    rtE
    vec( 1, 1, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec( 2, 1, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec( 3, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    // load in E, rs consumer at E-use: stall, then resolved via W in E
    vec( 4, 0, 0, 2'b10,  0,  0,  5,  5,  0,  1,  0, 2'b00, 0,   1,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec( 5, 0, 0, 2'b00,  0,  0,  0,  5,  0,  1,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec( 6, 0, 0, 2'b01,  5,  0,  6,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b10, 2'b00);
    // ALU in E, rt used in ID: stall, then forward from M
    vec( 7, 0, 0, 2'b01,  0,  0,  8,  0,  8,  0,  0, 2'b00, 0,   1,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec( 8, 0, 0, 2'b00,  0,  0,  0,  0,  8,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b01, 2'b00, 2'b00);
    // PC-link in E forwards to ID; rt also picks up W
    vec( 9, 0, 0, 2'b11,  0,  0, 31, 31,  8,  0,  3, 2'b00, 0,   0,  0, 2'b11, 2'b10, 2'b00, 2'b00);
    vec(10, 0, 0, 2'b11, 31,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b01, 2'b00);
    vec(11, 0, 0, 2'b11,  0, 31, 31, 31,  0,  0,  0, 2'b00, 0,   0,  0, 2'b11, 2'b00, 2'b00, 2'b10);
    vec(12, 0, 0, 2'b11, 31,  0, 31, 31,  0,  0,  0, 2'b00, 0,   0,  0, 2'b11, 2'b00, 2'b01, 2'b00);
    // M and W both hold r31: M wins
    vec(13, 0, 0, 2'b00, 31,  0,  0, 31,  0,  0,  0, 2'b00, 0,   0,  0, 2'b01, 2'b00, 2'b01, 2'b00);
    vec(14, 0, 0, 2'b00,  0, 31,  0, 31,  0,  0,  0, 2'b00, 0,   0,  0, 2'b10, 2'b00, 2'b00, 2'b10);
    // exception flush kills the ALU result headed for r3
    vec(15, 0, 0, 2'b01,  0,  0,  3,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(16, 0, 1, 2'b00,  0,  0,  0,  3,  0,  0,  0, 2'b00, 0,   0,  0, 2'b01, 2'b00, 2'b00, 2'b00);
    vec(17, 0, 0, 2'b00,  0,  0,  0,  3,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    // load sitting in M still stalls an ID-stage use
    vec(18, 0, 0, 2'b10,  0,  0,  9,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(19, 0, 0, 2'b00,  0,  0,  0,  0,  9,  0,  0, 2'b00, 0,   1,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(20, 0, 0, 2'b00,  0,  0,  0,  0,  9,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b10, 2'b00, 2'b00);
    // divide start then HI/LO users for ten busy cycles
    vec(21, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b10, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++)
      vec(22 + i, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, MDE, MDE, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(32, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 1,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    // mult start with a HI/LO user in ID; later start ignored while busy; flush does not abort
    vec(33, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b01, 1, MDE,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(34, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b10, 0,   0, MDE, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(35, 0, 1, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0, MDE, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(36, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0, MDE, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(37, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0, MDE, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(38, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0, MDE, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(39, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    // start under flush is ignored
    vec(40, 0, 1, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b01, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(41, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    // reset mid-divide wins over a concurrent start
    vec(42, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b10, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(43, 1, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b10, 0,   0, MDE, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(44, 0, 0, 2'b00,  0,  0,  0,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    // reset clears the tag pipeline
    vec(45, 0, 0, 2'b01,  0,  0,  4,  0,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    vec(46, 1, 0, 2'b00,  0,  0,  0,  4,  0,  0,  0, 2'b00, 0,   0,  0, 2'b01, 2'b00, 2'b00, 2'b00);
    vec(47, 0, 0, 2'b00,  0,  0,  0,  4,  0,  0,  0, 2'b00, 0,   0,  0, 2'b00, 2'b00, 2'b00, 2'b00);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
